// File: rtl/g15_io_pkg.sv
// Shared types and codes for the G15 slow-output path.
package g15_io_pkg;

    typedef logic [4:0] ob_code_t;

    localparam ob_code_t STOP_CODE  = 5'b00100;
    localparam ob_code_t WAIT_CODE  = 5'b00111;
    localparam ob_code_t BLANK_CODE = 5'b00000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LEADER = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } slow_out_state_t;

endpackage

// File: rtl/char_timer.sv
// Per-character cycle counter: runs 1..CHAR_CYCLES after start, flags strobe window and end.
module char_timer #(
    parameter int CHAR_CYCLES   = 16,
    parameter int STROBE_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    output logic strobe_active_o,
    output logic strobe_end_o,
    output logic done_o
);

    localparam int CW = $clog2(CHAR_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // A start on the done cycle restarts seamlessly, so back-to-back frames stay contiguous.
    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = CW'(1);
        end else if (cnt_q == CW'(CHAR_CYCLES)) begin
            cnt_d = '0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign strobe_active_o = (cnt_q != '0) && (cnt_q <= CW'(STROBE_CYCLES));
    assign strobe_end_o    = (cnt_q == CW'(STROBE_CYCLES));
    assign done_o          = (cnt_q == CW'(CHAR_CYCLES));

endmodule

// File: rtl/slow_out_dev.sv
// Slow-out device driver: captures OB char codes and strobes typewriter or punch.
// Optional punch leader frames are enabled with G15_PUNCH_LEADER_EN.
module slow_out_dev
    import g15_io_pkg::*;
#(
    parameter int CHAR_CYCLES   = 16,
    parameter int STROBE_CYCLES = 4
`ifdef G15_PUNCH_LEADER_EN
    ,
    parameter int LEADER_FRAMES = 8
`endif
) (
    input  logic       CLOCK,
    input  logic       rst,
    input  logic       SLOW_OUT,
    input  logic       OC2,
    input  logic       OB1,
    input  logic       OB2,
    input  logic       OB3,
    input  logic       OB4,
    input  logic       OB5,
    input  logic       CHAR_VALID,
    output logic [4:0] DEV_CODE,
    output logic       TYPE_STROBE,
    output logic       PUNCH_STROBE,
    output logic       DEV_BUSY,
    output logic       PUNCH_SYNC,
    output logic       OUT_DONE,
    output logic       OVERRUN
);

    slow_out_state_t state_q, state_d;
    ob_code_t        code_in, code_q, code_d;
    logic            dest_q, dest_d;
    logic            out_done_q, out_done_d;
    logic            overrun_q, overrun_d;
    logic            slow_out_q;
    logic            busy, capture, timer_start;
    logic            strobe_active, strobe_end, char_done;

`ifdef G15_PUNCH_LEADER_EN
    localparam int FW = (LEADER_FRAMES > 1) ? $clog2(LEADER_FRAMES) : 1;
    ob_code_t      held_q, held_d;
    logic          leader_pend_q, leader_pend_d;
    logic [FW-1:0] frame_q, frame_d;
`endif

    char_timer #(
        .CHAR_CYCLES  (CHAR_CYCLES),
        .STROBE_CYCLES(STROBE_CYCLES)
    ) u_timer (
        .clk_i          (CLOCK),
        .rst_i          (rst),
        .start_i        (timer_start),
        .strobe_active_o(strobe_active),
        .strobe_end_o   (strobe_end),
        .done_o         (char_done)
    );

    assign code_in = {OB5, OB4, OB3, OB2, OB1};
    assign busy    = (state_q != IDLE);
    // The OUT_DONE cycle is treated as busy so a char arriving on it is refused.
    assign capture = (state_q == IDLE) && SLOW_OUT && CHAR_VALID && !out_done_q;

    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        dest_d      = dest_q;
        out_done_d  = 1'b0;
        overrun_d   = overrun_q;
        timer_start = 1'b0;
`ifdef G15_PUNCH_LEADER_EN
        held_d        = held_q;
        frame_d       = frame_q;
        leader_pend_d = leader_pend_q;
        if (!slow_out_q && SLOW_OUT) begin
            leader_pend_d = 1'b1;
        end
`endif
        if (slow_out_q && !SLOW_OUT) begin
            overrun_d = 1'b0;
        end
        if (CHAR_VALID && (busy || out_done_q)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (capture) begin
                    dest_d = OC2;
                    if (code_in == STOP_CODE) begin
                        out_done_d = 1'b1;
                    end else if (code_in != WAIT_CODE) begin
                        timer_start = 1'b1;
`ifdef G15_PUNCH_LEADER_EN
                        if (leader_pend_q && OC2) begin
                            held_d        = code_in;
                            code_d        = BLANK_CODE;
                            frame_d       = '0;
                            leader_pend_d = 1'b0;
                            state_d       = LEADER;
                        end else begin
                            code_d  = code_in;
                            state_d = STROBE;
                        end
`else
                        code_d  = code_in;
                        state_d = STROBE;
`endif
                    end
                end
            end
            STROBE: begin
                if (strobe_end) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (char_done) begin
                    state_d = IDLE;
                end
            end
`ifdef G15_PUNCH_LEADER_EN
            LEADER: begin
                if (char_done) begin
                    timer_start = 1'b1;
                    if (frame_q == FW'(LEADER_FRAMES - 1)) begin
                        code_d  = held_q;
                        state_d = STROBE;
                    end else begin
                        frame_d = frame_q + FW'(1);
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (rst) begin
            state_q    <= IDLE;
            code_q     <= '0;
            dest_q     <= 1'b0;
            out_done_q <= 1'b0;
            overrun_q  <= 1'b0;
            slow_out_q <= 1'b0;
`ifdef G15_PUNCH_LEADER_EN
            held_q        <= '0;
            frame_q       <= '0;
            leader_pend_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            dest_q     <= dest_d;
            out_done_q <= out_done_d;
            overrun_q  <= overrun_d;
            slow_out_q <= SLOW_OUT;
`ifdef G15_PUNCH_LEADER_EN
            held_q        <= held_d;
            frame_q       <= frame_d;
            leader_pend_q <= leader_pend_d;
`endif
        end
    end

    assign DEV_CODE     = code_q;
    assign DEV_BUSY     = busy;
    assign TYPE_STROBE  = busy && strobe_active && !dest_q;
    assign PUNCH_STROBE = busy && strobe_active && dest_q;
    assign PUNCH_SYNC   = busy && char_done && dest_q;
    assign OUT_DONE     = out_done_q;
    assign OVERRUN      = overrun_q;

endmodule

// File: tb/tb_slow_out_dev.sv
// Randomised scoreboard bench for slow_out_dev; leader checks follow G15_PUNCH_LEADER_EN.
module tb_slow_out_dev;

    localparam int CYC    = 16;
    localparam int STB    = 4;
    localparam int LEAD_N = 8;
`ifdef G15_PUNCH_LEADER_EN
    localparam bit LEADER_ON = 1'b1;
`else
    localparam bit LEADER_ON = 1'b0;
`endif
    localparam logic [4:0] STOP_C = 5'b00100;
    localparam logic [4:0] WAIT_C = 5'b00111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       SLOW_OUT = 1'b0, OC2 = 1'b0, CHAR_VALID = 1'b0;
    logic       OB1 = 1'b0, OB2 = 1'b0, OB3 = 1'b0, OB4 = 1'b0, OB5 = 1'b0;
    logic [4:0] DEV_CODE;
    logic       TYPE_STROBE, PUNCH_STROBE, DEV_BUSY, PUNCH_SYNC, OUT_DONE, OVERRUN;

    slow_out_dev dut (
        .CLOCK(clk), .rst(rst), .SLOW_OUT(SLOW_OUT), .OC2(OC2),
        .OB1(OB1), .OB2(OB2), .OB3(OB3), .OB4(OB4), .OB5(OB5),
        .CHAR_VALID(CHAR_VALID), .DEV_CODE(DEV_CODE),
        .TYPE_STROBE(TYPE_STROBE), .PUNCH_STROBE(PUNCH_STROBE),
        .DEV_BUSY(DEV_BUSY), .PUNCH_SYNC(PUNCH_SYNC),
        .OUT_DONE(OUT_DONE), .OVERRUN(OVERRUN)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // Transaction word: {kind, start, code, busy_len, type_strobes, punch_strobes, syncs, code_changes}
    logic [55:0] exp_q[$];

    function automatic logic [55:0] mk(input bit k, input int st, input logic [4:0] c,
                                       input int len, input int ts, input int ps,
                                       input int sy, input int ch);
        return {k, st[15:0], c, len[11:0], ts[7:0], ps[7:0], sy[3:0], ch[1:0]};
    endfunction

    // ---------------- reference model ----------------
    int m_free = 0;       // earliest capture edge accepted
    int m_done = -10;     // edge at which the last STOP was captured
    bit m_ovr  = 1'b0;
    bit m_pend = 1'b0;
    bit m_slow = 1'b0;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic set_slow(input bit v);
        SLOW_OUT = v;
        if (v && !m_slow) m_pend = LEADER_ON;
        if (!v && m_slow) m_ovr = 1'b0;
        m_slow = v;
    endtask

    // Drives a one-cycle CHAR_VALID; sampled at edge cyc+1.
    task automatic pulse(input logic [4:0] code, input logic oc2);
        int e;
        int fr;
        {OB5, OB4, OB3, OB2, OB1} = code;
        OC2        = oc2;
        CHAR_VALID = 1'b1;
        e = cyc + 1;
        if (m_slow) begin
            if (e < m_free || e == m_done + 1) begin
                m_ovr = 1'b1;
            end else if (code == STOP_C) begin
                exp_q.push_back(mk(1'b1, e, 5'd0, 0, 0, 0, 0, 0));
                m_done = e;
            end else if (code != WAIT_C) begin
                fr = (m_pend && oc2) ? LEAD_N + 1 : 1;
                if (fr > 1) m_pend = 1'b0;
                exp_q.push_back(mk(1'b0, e, code, CYC * fr,
                                   oc2 ? 0 : STB * fr, oc2 ? STB * fr : 0,
                                   oc2 ? fr : 0, (fr > 1 && code != 5'd0) ? 1 : 0));
                m_free = e + CYC * fr + 1;
            end
        end
        @(posedge clk);
        #1;
        CHAR_VALID = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_dev_code"}, 32'(DEV_CODE), 32'd0);
        chk({tag, "_type_strobe"}, 32'(TYPE_STROBE), 32'd0);
        chk({tag, "_punch_strobe"}, 32'(PUNCH_STROBE), 32'd0);
        chk({tag, "_busy"}, 32'(DEV_BUSY), 32'd0);
        chk({tag, "_sync"}, 32'(PUNCH_SYNC), 32'd0);
        chk({tag, "_done"}, 32'(OUT_DONE), 32'd0);
        chk({tag, "_overrun"}, 32'(OVERRUN), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        rst        = 1'b1;
        CHAR_VALID = 1'b0;
        exp_q.delete();
        tick(1);
        chk_idle_outputs(tag);
        tick(1);
        rst    = 1'b0;
        m_ovr  = 1'b0;
        m_free = 0;
        m_done = -10;
        m_pend = LEADER_ON && m_slow;
        tick(1);
    endtask

    task automatic clear_overrun();
        set_slow(1'b0);
        tick(2);
        chk("overrun_clear", 32'(OVERRUN), 32'(m_ovr));
        set_slow(1'b1);
        tick(2);
    endtask

    // ---------------- monitor / scoreboard ----------------
    bit         in_char = 1'b0;
    int         o_start, o_len, o_ts, o_ps, o_sy, o_ch;
    logic [4:0] o_code;

    task automatic check_item(input string name, input logic [55:0] got);
        logic [55:0] exp;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL %s: got %0h expected nothing (cycle %0d)", name, got, cyc);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                fails++;
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            in_char = 1'b0;
        end else begin
            if (DEV_BUSY) begin
                if (!in_char) begin
                    in_char = 1'b1;
                    o_start = cyc;
                    o_len = 0; o_ts = 0; o_ps = 0; o_sy = 0; o_ch = 0;
                    o_code = DEV_CODE;
                end else if (DEV_CODE != o_code) begin
                    o_ch++;
                    o_code = DEV_CODE;
                end
                o_len++;
                o_ts += int'(TYPE_STROBE);
                o_ps += int'(PUNCH_STROBE);
                o_sy += int'(PUNCH_SYNC);
            end else begin
                if (in_char) begin
                    in_char = 1'b0;
                    check_item("char", mk(1'b0, o_start, o_code, o_len, o_ts, o_ps, o_sy, o_ch));
                end
                if (TYPE_STROBE || PUNCH_STROBE || PUNCH_SYNC) begin
                    tests++;
                    fails++;
                    $display("FAIL idle_strobe: got %b%b%b expected 000 (cycle %0d)",
                             TYPE_STROBE, PUNCH_STROBE, PUNCH_SYNC, cyc);
                end
            end
            if (OUT_DONE) check_item("out_done", mk(1'b1, cyc, 5'd0, 0, 0, 0, 0, 0));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [4:0] c;
        int r;
        tick(2);
        do_reset("reset");
        set_slow(1'b1);
        tick(2);

        // Typewriter and punch characters
        pulse(5'b10011, 1'b0);
        tick(20);
        pulse(5'b01010, 1'b1);
        tick(20);

        // Overrun mid-char keeps the current code
        pulse(5'b11001, 1'b0);
        tick(4);
        pulse(5'b00010, 1'b0);
        chk("overrun_set", 32'(OVERRUN), 32'(m_ovr));
        chk("dev_code_kept", 32'(DEV_CODE), 32'h19);
        tick(12);
        chk("overrun_sticky", 32'(OVERRUN), 32'(m_ovr));
        tick(5);
        clear_overrun();

        // Arrival in the last busy cycle is refused; the next cycle is accepted
        pulse(5'b10101, 1'b1);
        tick(15);
        pulse(5'b01110, 1'b1);
        chk("overrun_last_busy", 32'(OVERRUN), 32'(m_ovr));
        pulse(5'b01110, 1'b1);
        tick(20);
        clear_overrun();

        // STOP, then a char during OUT_DONE; WAIT is silent
        pulse(STOP_C, 1'b1);
        pulse(5'b00011, 1'b0);
        chk("overrun_on_done", 32'(OVERRUN), 32'(m_ovr));
        tick(3);
        clear_overrun();
        pulse(WAIT_C, 1'b0);
        tick(3);
        chk("wait_no_overrun", 32'(OVERRUN), 32'(m_ovr));

        // SLOW_OUT low in IDLE ignores CHAR_VALID
        set_slow(1'b0);
        tick(2);
        pulse(5'b11111, 1'b0);
        tick(3);
        chk("slow_off_ignored", 32'(OVERRUN), 32'd0);
        set_slow(1'b1);
        tick(2);

        // Reset mid-strobe, then a fresh char
        pulse(5'b11100, 1'b1);
        tick(2);
        do_reset("mid_reset");
        pulse(5'b00110, 1'b0);
        tick(20);

`ifdef G15_PUNCH_LEADER_EN
        // Leader frames precede the first punch char after SLOW_OUT rises
        set_slow(1'b0);
        tick(2);
        set_slow(1'b1);
        tick(2);
        pulse(5'b00011, 1'b0);
        tick(20);
        pulse(5'b00001, 1'b1);
        tick(CYC * (LEAD_N + 1) + 4);
        pulse(5'b00001, 1'b1);
        tick(20);
`endif

        // Randomised traffic
        for (int i = 0; i < 70; i++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                set_slow(1'b0);
                tick(1);
                set_slow(1'b1);
                tick(1);
            end
            c = (r == 1) ? STOP_C : (r == 2) ? WAIT_C : 5'($urandom_range(0, 31));
            pulse(c, 1'($urandom_range(0, 1)));
            chk("overrun_rand", 32'(OVERRUN), 32'(m_ovr));
            if ($urandom_range(0, 3) == 0) tick(int'($urandom_range(0, 10)));
            else tick(int'($urandom_range(14, 20)));
        end

        tick(CYC * (LEAD_N + 1) + 10);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
